// File: rtl/vex_axi_pkg.sv
// rtl/vex_axi_pkg.sv - AXI response/burst codes, size helper and initiator FSM states
package vex_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  function automatic logic [2:0] axi_size(input int data_w);
    case (data_w)
      8:       return 3'd0;
      16:      return 3'd1;
      32:      return 3'd2;
      64:      return 3'd3;
      128:     return 3'd4;
      default: return 3'd2;
    endcase
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } init_state_t;

endpackage

// File: rtl/axi_pattern_gen.sv
// rtl/axi_pattern_gen.sv - test pattern SEED+idx replicated into every 32-bit lane
module axi_pattern_gen #(
  parameter int          DATA_W = 32,
  parameter logic [31:0] SEED   = 32'hA5A5_0000,
  parameter int          IDX_W  = 8
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] data
);

  logic [31:0] word;

  assign word = SEED + 32'(idx);
  assign data = {(DATA_W/32){word}};

endmodule

// File: rtl/axi_ram_initiator.sv
// rtl/axi_ram_initiator.sv - AXI4 pattern fill and read-back checker; AXI_INIT_CHECK_EN enables read-back
module axi_ram_initiator
  import vex_axi_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter int               DATA_W    = 32,
  parameter int               ID_W      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int               WORDS     = 64,
  parameter int               BURST_LEN = 8,
  parameter logic [31:0]      SEED      = 32'hA5A5_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  localparam int BYTES       = DATA_W / 8;
  localparam int BURST_BYTES = BURST_LEN * BYTES;
  localparam int NBURST      = WORDS / BURST_LEN;
  localparam int IDX_W       = $clog2(WORDS + 1);
  localparam int BCNT_W      = $clog2(BURST_LEN + 1);
  localparam int BUR_W       = $clog2(NBURST + 1);
  localparam logic [BCNT_W-1:0] LAST_BEAT  = BCNT_W'(BURST_LEN - 1);
  localparam logic [BUR_W-1:0]  LAST_BURST = BUR_W'(NBURST - 1);

  init_state_t       state, state_n;
  logic [IDX_W-1:0]  beat, beat_n;
  logic [BCNT_W-1:0] bcnt, bcnt_n;
  logic [BUR_W-1:0]  burst, burst_n;
  logic [DATA_W-1:0] pat_next;
  logic              bad_b;
  logic              unused_in;

  function automatic logic [ADDR_W-1:0] burst_addr(input logic [BUR_W-1:0] b);
    return BASE_ADDR + ADDR_W'(b) * ADDR_W'(BURST_BYTES);
  endfunction

  assign awid    = '0;
  assign awlen   = 8'(BURST_LEN - 1);
  assign awsize  = axi_size(DATA_W);
  assign awburst = BURST_INCR;
  assign arid    = '0;
  assign arlen   = 8'(BURST_LEN - 1);
  assign arsize  = axi_size(DATA_W);
  assign arburst = BURST_INCR;

  // Write data is registered, so the generator looks at the index of the beat about to be presented.
  axi_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED), .IDX_W(IDX_W)) u_pat_wr (
    .idx  (beat_n),
    .data (pat_next)
  );

  assign bad_b = (state == ST_WR_RESP) && bvalid && (bresp != RESP_OKAY);

  always_comb begin
    state_n = state;
    beat_n  = beat;
    bcnt_n  = bcnt;
    burst_n = burst;
    case (state)
      ST_IDLE: if (start) begin
        state_n = ST_WR_ADDR;
        beat_n  = '0;
        bcnt_n  = '0;
        burst_n = '0;
      end
      ST_WR_ADDR: if (awvalid && awready) state_n = ST_WR_DATA;
      ST_WR_DATA: if (wvalid && wready) begin
        beat_n = beat + IDX_W'(1);
        if (bcnt == LAST_BEAT) begin
          bcnt_n  = '0;
          state_n = ST_WR_RESP;
        end else begin
          bcnt_n = bcnt + BCNT_W'(1);
        end
      end
      ST_WR_RESP: if (bready && bvalid) begin
        if (burst == LAST_BURST) begin
          burst_n = '0;
          beat_n  = '0;
`ifdef AXI_INIT_CHECK_EN
          state_n = ST_RD_ADDR;
`else
          state_n = ST_DONE;
`endif
        end else begin
          burst_n = burst + BUR_W'(1);
          state_n = ST_WR_ADDR;
        end
      end
`ifdef AXI_INIT_CHECK_EN
      ST_RD_ADDR: if (arvalid && arready) state_n = ST_RD_DATA;
      ST_RD_DATA: if (rready && rvalid) begin
        beat_n = beat + IDX_W'(1);
        // The burst length is ours; a misplaced rlast is reported, never obeyed.
        if (bcnt == LAST_BEAT) begin
          bcnt_n = '0;
          if (burst == LAST_BURST) begin
            state_n = ST_DONE;
          end else begin
            burst_n = burst + BUR_W'(1);
            state_n = ST_RD_ADDR;
          end
        end else begin
          bcnt_n = bcnt + BCNT_W'(1);
        end
      end
`endif
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

`ifdef AXI_INIT_CHECK_EN
  logic [DATA_W-1:0] pat_cur;
  logic              bad_r;

  axi_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED), .IDX_W(IDX_W)) u_pat_rd (
    .idx  (beat),
    .data (pat_cur)
  );

  assign bad_r = (state == ST_RD_DATA) && rvalid &&
                 ((rdata != pat_cur) || (rresp != RESP_OKAY) || (rlast != (bcnt == LAST_BEAT)));
  assign unused_in = ^{bid, rid};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arvalid <= 1'b0;
      araddr  <= '0;
      rready  <= 1'b0;
    end else begin
      arvalid <= (state_n == ST_RD_ADDR);
      if (state_n == ST_RD_ADDR) araddr <= burst_addr(burst_n);
      rready  <= (state_n == ST_RD_DATA);
    end
  end
`else
  assign arvalid   = 1'b0;
  assign araddr    = '0;
  assign rready    = 1'b0;
  assign unused_in = ^{bid, rid, arready, rdata, rresp, rlast, rvalid};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      beat           <= '0;
      bcnt           <= '0;
      burst          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      awvalid        <= 1'b0;
      awaddr         <= '0;
      wvalid         <= 1'b0;
      wlast          <= 1'b0;
      wdata          <= '0;
      wstrb          <= '0;
      bready         <= 1'b0;
      error          <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state   <= state_n;
      beat    <= beat_n;
      bcnt    <= bcnt_n;
      burst   <= burst_n;
      busy    <= (state_n != ST_IDLE) && (state_n != ST_DONE);
      done    <= (state_n == ST_DONE);
      awvalid <= (state_n == ST_WR_ADDR);
      if (state_n == ST_WR_ADDR) awaddr <= burst_addr(burst_n);
      wvalid  <= (state_n == ST_WR_DATA);
      wlast   <= (state_n == ST_WR_DATA) && (bcnt_n == LAST_BEAT);
      if (state_n == ST_WR_DATA) begin
        wdata <= pat_next;
        wstrb <= '1;
      end
      bready  <= (state_n == ST_WR_RESP);

      if (state == ST_IDLE && start) begin
        error          <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
      end else begin
        // awaddr still holds the address of the burst being acknowledged.
        if (bad_b) begin
          error <= 1'b1;
          if (!error) first_err_addr <= awaddr;
`ifndef AXI_INIT_CHECK_EN
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`endif
        end
`ifdef AXI_INIT_CHECK_EN
        if (bad_r) begin
          error <= 1'b1;
          if (!error) first_err_addr <= BASE_ADDR + ADDR_W'(beat) * ADDR_W'(BYTES);
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_initiator.sv
// tb/tb_axi_ram_initiator.sv - randomized AXI RAM responder and directed checks for axi_ram_initiator
module tb_axi_ram_initiator;

  localparam int          BL    = 8;
  localparam int          WORDS = 64;
  localparam int          NB    = WORDS / BL;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] SEED  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, error;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mem [WORDS];
  bit          stall;
  logic [31:0] corrupt_addr;
  int          bad_burst;
  int          aw_cnt, w_cnt, ar_cnt, r_cnt, arv_hi;

  always #5 clk = ~clk;

  axi_ram_initiator #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .BASE_ADDR(BASE),
    .WORDS(WORDS), .BURST_LEN(BL), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .error(error), .err_count(err_count), .first_err_addr(first_err_addr),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Responder: drives on the falling edge, samples handshakes just before the rising edge.
  initial begin : responder
    logic [31:0] cur_aw, r_base, p_awaddr, p_wdata;
    logic        p_wlast, aw_stall, w_stall, b_pend, r_act;
    int          wbeat, rbeat, b_burst, idx;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
    b_pend = 0; r_act = 0; aw_stall = 0; w_stall = 0;
    wbeat = 0; rbeat = 0; b_burst = 0; cur_aw = 0; r_base = 0; p_awaddr = 0; p_wdata = 0; p_wlast = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
      end else begin
        awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        bvalid  = b_pend;
        bresp   = (b_burst == bad_burst) ? 2'b10 : 2'b00;
        rvalid  = r_act && (!stall || ($urandom_range(0, 1) == 1));
        if (r_act) begin
          idx   = int'((r_base - BASE) >> 2) + rbeat;
          rdata = mem[idx % WORDS];
          if (r_base + 32'(rbeat * 4) == corrupt_addr) rdata = rdata ^ 32'h0000_0100;
          rlast = (rbeat == BL - 1);
        end
      end
      #4;
      if (reset) begin
        b_pend = 0; r_act = 0; aw_stall = 0; w_stall = 0; wbeat = 0; rbeat = 0;
      end else begin
        if (start && !busy) begin
          aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; arv_hi = 0;
        end
        if (aw_stall) begin
          chk("aw_hold_valid", awvalid, 1);
          chk("aw_hold_addr", awaddr, p_awaddr);
        end
        if (w_stall) begin
          chk("w_hold_valid", wvalid, 1);
          chk("w_hold_data", wdata, p_wdata);
          chk("w_hold_last", wlast, p_wlast);
        end
        if (arvalid) arv_hi++;
        if (awvalid && awready) begin
          chk("awaddr", awaddr, 32'(BASE + 32'(aw_cnt * BL * 4)));
          chk("awlen", awlen, BL - 1);
          chk("awsize", awsize, 2);
          chk("awburst", awburst, 1);
          chk("awid", awid, 0);
          cur_aw = awaddr;
          wbeat  = 0;
          aw_cnt++;
        end
        if (wvalid && wready) begin
          idx = int'((cur_aw - BASE) >> 2) + wbeat;
          chk("wdata", wdata, 32'(SEED + 32'(idx)));
          chk("wlast", wlast, (wbeat == BL - 1));
          chk("wstrb", wstrb, 4'hF);
          mem[idx % WORDS] = wdata;
          w_cnt++;
          wbeat++;
          if (wbeat == BL) begin
            b_pend  = 1;
            b_burst = aw_cnt - 1;
          end
        end
        if (bvalid && bready) b_pend = 0;
        if (rvalid && rready) begin
          rbeat++;
          r_cnt++;
          if (rbeat == BL) r_act = 0;
        end
        if (arvalid && arready) begin
          chk("araddr", araddr, 32'(BASE + 32'(ar_cnt * BL * 4)));
          chk("arlen", arlen, BL - 1);
          chk("arsize", arsize, 2);
          chk("arburst", arburst, 1);
          r_base = araddr;
          rbeat  = 0;
          r_act  = 1;
          ar_cnt++;
        end
        aw_stall = awvalid && !awready;
        w_stall  = wvalid && !wready;
        p_awaddr = awaddr;
        p_wdata  = wdata;
        p_wlast  = wlast;
      end
    end
  end

  task automatic run(input bit mid_start);
    int  dones;
    bit  seen;
    dones = 0;
    seen  = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk("awvalid_after_start", awvalid, 1);
    chk("busy_after_start", busy, 1);
    for (int k = 0; k < 4000 && !seen; k++) begin
      @(negedge clk);
      start = (mid_start && k == 20);
      if (done) begin
        dones++;
        seen = 1;
      end
    end
    start = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("done_pulses", dones, 1);
  endtask

  task automatic verify(input string tag, input bit exp_err, input int exp_cnt, input logic [31:0] exp_fea);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_err_count"}, err_count, exp_cnt);
    chk({tag, "_first_err_addr"}, first_err_addr, exp_fea);
    chk({tag, "_aw_bursts"}, aw_cnt, NB);
    chk({tag, "_w_beats"}, w_cnt, WORDS);
    chk({tag, "_busy_idle"}, busy, 0);
`ifdef AXI_INIT_CHECK_EN
    chk({tag, "_ar_bursts"}, ar_cnt, NB);
    chk({tag, "_r_beats"}, r_cnt, WORDS);
`else
    chk({tag, "_arvalid_cycles"}, arv_hi, 0);
    chk({tag, "_ar_bursts"}, ar_cnt, 0);
`endif
  endtask

  initial begin : main
    logic [31:0] raddr;
    int          rb;
    bit          hit;
    reset = 1; start = 0; stall = 0; corrupt_addr = 32'hFFFF_FFFF; bad_burst = -1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_first_err_addr", first_err_addr, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_wdata", wdata, 0);
    @(negedge clk) reset = 0;

    run(0);
    verify("clean", 0, 0, 0);
    chk("mem_at_0x10", mem[4], 32'hA5A5_0004);

    stall = 1;
    run(1);
    verify("stall", 0, 0, 0);
    stall = 0;

    bad_burst = 1;
    run(0);
`ifdef AXI_INIT_CHECK_EN
    verify("bresp", 1, 0, 32'h20);
`else
    verify("bresp", 1, 1, 32'h20);
`endif
    bad_burst = -1;

    corrupt_addr = 32'h44;
    run(0);
`ifdef AXI_INIT_CHECK_EN
    verify("corrupt44", 1, 1, 32'h44);
`else
    verify("corrupt44", 0, 0, 0);
`endif

    stall = 1;
    raddr = BASE + 32'($urandom_range(0, WORDS - 1) * 4);
    corrupt_addr = raddr;
    run(0);
`ifdef AXI_INIT_CHECK_EN
    verify("corrupt_rand", 1, 1, raddr);
`else
    verify("corrupt_rand", 0, 0, 0);
`endif

    rb = int'($urandom_range(0, NB - 1));
    bad_burst = rb;
    run(0);
`ifdef AXI_INIT_CHECK_EN
    verify("bresp_and_corrupt", 1, 1, 32'(rb * BL * 4));
`else
    verify("bresp_and_corrupt", 1, 1, 32'(rb * BL * 4));
`endif
    bad_burst = -1;
    corrupt_addr = 32'hFFFF_FFFF;
    stall = 0;

    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      hit = (w_cnt == 3);
    end
    chk("reached_beat3", w_cnt, 3);
    chk("beat3_wdata", wdata, 32'hA5A5_0003);
    #1 reset = 1;
    #1;
    chk("arst_awvalid", awvalid, 0);
    chk("arst_wvalid", wvalid, 0);
    chk("arst_wlast", wlast, 0);
    chk("arst_wdata", wdata, 0);
    chk("arst_awaddr", awaddr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_bready", bready, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    run(0);
    verify("after_reset", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
